// File: rtl/layer_2_maxpool2x2.sv
// Streaming 2x2 stride-2 FP32 max-pool behind the layer-2 conv stage.
// Ports: Clk, Rst (async low), data_in/valid_in, data_out/valid_out/frame_done.
module layer_2_maxpool2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 208
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] SIGN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Map FP bits to an unsigned key whose integer order
  // matches the float order (-0 sorts just below +0).
  function automatic logic [DATA_WIDTH-1:0] fp_key(
    input logic [DATA_WIDTH-1:0] x
  );
    return x[DATA_WIDTH-1] ? ~x : (x ^ SIGN);
  endfunction

  // Ties keep the first operand.
  function automatic logic [DATA_WIDTH-1:0] fp_max(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return (fp_key(a) >= fp_key(b)) ? a : b;
  endfunction

  logic [CW-1:0]         col_cnt;
  logic [CW-1:0]         row_cnt;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] linebuf [HALF];

  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] top;
  logic                  col_last;
  logic                  row_last;
  logic                  col_odd;
  logic                  row_odd;

  assign idx      = IW'(col_cnt >> 1);
  assign col_last = (col_cnt == LAST);
  assign row_last = (row_cnt == LAST);
  assign col_odd  = col_cnt[0];
  assign row_odd  = row_cnt[0];
  assign hmax     = fp_max(hold_reg, data_in);
  assign top      = linebuf[idx];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      hold_reg   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        col_cnt <= col_last ? '0 : col_cnt + CW'(1);
        if (col_last)
          row_cnt <= row_last ? '0 : row_cnt + CW'(1);
        if (!col_odd) begin
          hold_reg <= data_in;
        end else if (row_odd) begin
          data_out   <= fp_max(top, hmax);
          valid_out  <= 1'b1;
          frame_done <= col_last && row_last;
        end
      end
    end
  end

  // Every odd-row read is preceded by an even-row write to
  // the same entry, so contents need no reset.
  always_ff @(posedge Clk) begin
    if (valid_in && col_odd && !row_odd)
      linebuf[idx] <= hmax;
  end

endmodule

// File: tb/tb_layer_2_maxpool2x2.sv
// Directed bench for layer_2_maxpool2x2 at IMG_SIZE 4 and 2.
// Table vectors plus gapped, multi-frame and reset sequences.
module tb_layer_2_maxpool2x2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] d4 = '0;
  logic        v4 = 1'b0;
  logic [31:0] o4;
  logic        vo4;
  logic        fd4;
  logic [31:0] d2 = '0;
  logic        v2 = 1'b0;
  logic [31:0] o2;
  logic        vo2;
  logic        fd2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  layer_2_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) u4 (
    .Clk(Clk), .Rst(Rst), .data_in(d4), .valid_in(v4),
    .data_out(o4), .valid_out(vo4), .frame_done(fd4)
  );

  layer_2_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(2)) u2 (
    .Clk(Clk), .Rst(Rst), .data_in(d2), .valid_in(v2),
    .data_out(o2), .valid_out(vo2), .frame_done(fd2)
  );

  logic [31:0] q_data[$];
  logic        q_fd[$];
  int          q_cyc[$];
  int          exp_cyc[$];

  always @(negedge Clk) begin
    if (vo4) begin
      q_data.push_back(o4);
      q_fd.push_back(fd4);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] pix [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };

  logic [31:0] exp_pos [4] = '{
    32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000
  };

  logic [31:0] exp_neg [4] = '{
    32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000
  };

  function automatic bit closes(input int i);
    return ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
  endfunction

  task automatic beat4(input logic [31:0] v, input int i);
    @(negedge Clk);
    d4 = v;
    v4 = 1'b1;
    if (closes(i)) exp_cyc.push_back(cyc + 1);
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(negedge Clk);
      v4 = 1'b0;
      d4 = 32'hDEADBEEF;
    end
  endtask

  task automatic flush();
    q_data.delete();
    q_fd.delete();
    q_cyc.delete();
    exp_cyc.delete();
  endtask

  task automatic chk_frame(input string tag, input int base,
                           input logic [31:0] e [4]);
    for (int k = 0; k < 4; k++) begin
      if (base + k < q_data.size()) begin
        chk({tag, "_data"}, q_data[base+k], e[k]);
        chk({tag, "_fd"}, {31'b0, q_fd[base+k]},
            (k == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic chk_timing(input string tag);
    for (int k = 0; k < q_cyc.size(); k++)
      if (k < exp_cyc.size())
        chk({tag, "_lat"}, q_cyc[k], exp_cyc[k]);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] y;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{32'h80000000, 32'h00000000, 32'hBF800000,
              32'hC0000000, 32'h00000000};
    vt[1] = '{32'hC0400000, 32'hBFC00000, 32'hC0000000,
              32'hC0800000, 32'hBFC00000};
    vt[2] = '{32'h3F800000, 32'h40000000, 32'h40400000,
              32'h3F000000, 32'h40400000};
    vt[3] = '{32'h80000000, 32'h80000000, 32'h80000000,
              32'h80000000, 32'h80000000};
    vt[4] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000,
              32'h00000001, 32'h7F7FFFFF};
    vt[5] = '{32'hC0000000, 32'hC0400000, 32'h00000000,
              32'h80000000, 32'h00000000};

    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_data4", o4, 32'h0);
    chk("rst_valid4", {31'b0, vo4}, 32'h0);
    chk("rst_fd4", {31'b0, fd4}, 32'h0);
    chk("rst_data2", o2, 32'h0);
    Rst = 1'b1;
    idle4(2);

    // continuous frame
    flush();
    for (int i = 0; i < 16; i++) beat4(pix[i], i);
    idle4(4);
    chk("cont_count", q_data.size(), 4);
    chk_frame("cont", 0, exp_pos);
    chk_timing("cont");

    // gapped frame: 1,0,0,1,0,0,...
    flush();
    for (int i = 0; i < 16; i++) begin
      beat4(pix[i], i);
      idle4(2);
    end
    idle4(3);
    chk("gap_count", q_data.size(), 4);
    chk_frame("gap", 0, exp_pos);
    chk_timing("gap");

    // two back-to-back frames, second negated
    flush();
    for (int i = 0; i < 32; i++)
      beat4((i < 16) ? pix[i] : (pix[i-16] ^ 32'h80000000), i % 16);
    idle4(4);
    chk("b2b_count", q_data.size(), 8);
    chk_frame("b2b1", 0, exp_pos);
    chk_frame("b2b2", 4, exp_neg);
    chk_timing("b2b");

    // mid-frame reset after 7 pixels
    flush();
    for (int i = 0; i < 7; i++) beat4(pix[i], i);
    @(negedge Clk);
    v4 = 1'b0;
    Rst = 1'b0;
    #1;
    chk("midrst_data", o4, 32'h0);
    chk("midrst_valid", {31'b0, vo4}, 32'h0);
    chk("midrst_fd", {31'b0, fd4}, 32'h0);
    chk("pre_rst_count", q_data.size(), 1);
    if (q_data.size() > 0)
      chk("pre_rst_data", q_data[0], exp_pos[0]);
    @(negedge Clk);
    chk("midrst_hold", o4, 32'h0);
    Rst = 1'b1;
    flush();
    for (int i = 0; i < 16; i++) beat4(pix[i], i);
    idle4(4);
    chk("post_rst_count", q_data.size(), 4);
    chk_frame("post_rst", 0, exp_pos);
    chk_timing("post_rst");

    // IMG_SIZE=2 table, frames back to back
    for (int n = 0; n < 6; n++) begin
      @(negedge Clk); d2 = vt[n].a; v2 = 1'b1;
      @(negedge Clk); d2 = vt[n].b;
      @(negedge Clk); d2 = vt[n].c;
      @(negedge Clk); d2 = vt[n].d;
      @(negedge Clk);
      v2 = 1'b0;
      d2 = 32'h12345678;
      chk($sformatf("v%0d_data", n), o2, vt[n].y);
      chk($sformatf("v%0d_valid", n), {31'b0, vo2}, 32'h1);
      chk($sformatf("v%0d_fd", n), {31'b0, fd2}, 32'h1);
      @(negedge Clk);
      chk($sformatf("v%0d_vdrop", n), {31'b0, vo2}, 32'h0);
      chk($sformatf("v%0d_fdrop", n), {31'b0, fd2}, 32'h0);
      chk($sformatf("v%0d_hold", n), o2, vt[n].y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_2_maxpool2x2.md
Name: layer_2_maxpool2x2

Overview:
- Streaming 2x2, stride-2 max-pool stage directly downstream of the layer-2 featuremap convolution output.
- Consumes one FP32 pixel per valid_in beat in raster order over an IMG_SIZE x IMG_SIZE map.
- Emits one FP32 max per 2x2 window in raster order over an (IMG_SIZE/2) x (IMG_SIZE/2) map.
- Uses one half-row line buffer; no backpressure, matching the valid-only streaming style of the conv stage.

Parameters:
- DATA_WIDTH, 32, pixel width; IEEE-754 single precision.
- IMG_SIZE, 208, input map width and height; must be even and >= 2.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  input pixel, FP32.
- valid_in  input  1  data_in is valid this cycle; may deassert at any time (gaps allowed).
- data_out  output  DATA_WIDTH  pooled pixel, FP32.
- valid_out  output  1  one-cycle pulse; data_out is valid.
- frame_done  output  1  one-cycle pulse, asserted together with the last pooled pixel of a frame.

Behaviour:
- Reset (Rst low, asynchronous):
  - col_cnt=0, row_cnt=0, hold_reg=0.
  - data_out=0, valid_out=0, frame_done=0.
  - Line-buffer contents are not cleared. Every odd-row read of an entry is preceded by an even-row write to it, so stale contents are never used.
- Counters:
  - col_cnt runs 0..IMG_SIZE-1; row_cnt runs 0..IMG_SIZE-1.
  - Both advance only on valid_in=1.
  - col_cnt wraps to 0 after IMG_SIZE-1 and increments row_cnt.
  - row_cnt wraps to 0 after IMG_SIZE-1. The next beat starts a new frame with no dead cycle.
  - When valid_in=0, all state holds and no output is produced.
- FP compare (combinational, shared function):
  - key(x) = ~x if x[31]=1, else x ^ 32'h80000000.
  - max(a,b) = a if key(a) >= key(b), else b.
  - This gives -0 < +0, and equal keys select a (the earlier/left operand).
  - NaN is not expected upstream; whatever the key ordering yields is acceptable.
- Even col_cnt: hold_reg <= data_in.
- Odd col_cnt: hmax = max(hold_reg, data_in), with idx = col_cnt>>1.
  - Even row_cnt: linebuf[idx] <= hmax. No output.
  - Odd row_cnt: data_out <= max(linebuf[idx], hmax); valid_out <= 1 next cycle.
- Operand order for the final compare is top-row first; ties select the top-row value.
- Latency: valid_out rises exactly 1 cycle after the accepting edge of the bottom-right pixel of each window.
- Line buffer:
  - IMG_SIZE/2 entries x DATA_WIDTH.
  - Read is combinational (or same-cycle registered with a matching pipeline); write and read never target the same entry in the same cycle.
- frame_done=1 with valid_out when the emitted window is at row_cnt=IMG_SIZE-1, col_cnt=IMG_SIZE-1.
- Outputs valid_out and frame_done return to 0 on the cycle after the pulse. data_out holds its last value.
- Output rate: at most one output per 4 inputs, so no overflow is possible.
- Mid-frame reset: all counters return to 0. The next valid_in beat is treated as pixel (0,0) of a fresh frame, and no partial window is emitted.
- Throughput: back-to-back valid_in is supported at 1 pixel/cycle indefinitely.

Test Plan:
- IMG_SIZE=4, continuous valid, pixels 1.0..16.0 raster (0x3F800000...):
  - valid_out pulses 4 times with data_out = 6.0, 8.0, 14.0, 16.0.
  - frame_done coincides with 16.0.
- Negative/zero ordering, IMG_SIZE=2, inputs -0.0 (0x80000000), +0.0, -1.0, -2.0:
  - output = 0x00000000.
- Inputs -3.0, -1.5, -2.0, -4.0:
  - output = 0xBFC00000 (-1.5).
- Gapped stream: same as the first test with valid_in toggled 1,0,0,1,...:
  - identical outputs.
  - Each valid_out arrives 1 cycle after its window's last accepted beat.
  - No output during gaps.
- Two back-to-back frames at IMG_SIZE=4, second frame with values negated:
  - 8 outputs total; the second set is -1.0, -3.0, -9.0, -11.0.
  - frame_done pulses twice.
- Reset mid-frame: assert Rst low for 1 cycle after 7 pixels, then send a full frame:
  - no spurious valid_out.
  - Outputs match the first test exactly.
  - All outputs read 0 while Rst is low.
